// File: rtl/biriscv_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : biriscv_mem_responder
// Brief    : Behavioural dual-port memory responder for the biRISC-V core.
//            Serves 64-bit instruction fetches and 32-bit tagged data
//            requests from one word array. Each port has a fixed LATENCY
//            response pipeline. Only reset clears the pipelines; the array
//            keeps its contents across reset.
// Revision : 1.0 - initial release
// ============================================================================
module biriscv_mem_responder #(
  parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
  parameter int          MEM_WORDS = 16384,
  parameter int          LATENCY   = 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        stall_i,
  // Instruction fetch port
  input  logic        mem_i_rd_i,
  input  logic [31:0] mem_i_pc_i,
  input  logic        mem_i_flush_i,
  input  logic        mem_i_invalidate_i,
  output logic        mem_i_accept_o,
  output logic        mem_i_valid_o,
  output logic        mem_i_error_o,
  output logic [63:0] mem_i_inst_o,
  // Data port
  input  logic [31:0] mem_d_addr_i,
  input  logic [31:0] mem_d_data_wr_i,
  input  logic        mem_d_rd_i,
  input  logic [3:0]  mem_d_wr_i,
  input  logic [10:0] mem_d_req_tag_i,
  input  logic        mem_d_cacheable_i,
  input  logic        mem_d_flush_i,
  input  logic        mem_d_invalidate_i,
  input  logic        mem_d_writeback_i,
  output logic        mem_d_accept_o,
  output logic        mem_d_ack_o,
  output logic        mem_d_error_o,
  output logic [31:0] mem_d_data_rd_o,
  output logic [10:0] mem_d_resp_tag_o
);

  localparam int          AW          = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam logic [32:0] WORDS_LIMIT = 33'(MEM_WORDS);

  logic [31:0] mem [MEM_WORDS];

  // Request decode and address range checks
  logic        accept;
  logic        f_fire, d_fire;
  logic [31:0] f_base, f_off, d_off;
  logic [32:0] f_idx0, f_idx1, d_idx;
  logic        f_in_range, d_in_range;
  logic [31:0] f_word0, f_word1, d_word;
  logic        d_is_write, d_is_read, d_is_cmo;
  logic        f_err_now, d_err_now;
  logic [63:0] f_inst_now;
  logic [31:0] d_data_now;

  assign accept         = !stall_i && !rst_i;
  assign mem_i_accept_o = accept;
  assign mem_d_accept_o = accept;

  // A fetch always returns the aligned 8-byte pair, so pc[2:0] is dropped
  assign f_base     = {mem_i_pc_i[31:3], 3'b000};
  assign f_off      = f_base - BASE_ADDR;
  assign f_idx0     = {3'b000, f_off[31:2]};
  assign f_idx1     = f_idx0 + 33'd1;
  assign f_in_range = (f_base >= BASE_ADDR) && (f_idx1 < WORDS_LIMIT);

  assign d_off      = mem_d_addr_i - BASE_ADDR;
  assign d_idx      = {3'b000, d_off[31:2]};
  assign d_in_range = (mem_d_addr_i >= BASE_ADDR) && (d_idx < WORDS_LIMIT);

  // Reads are only indexed when in range, so the narrowed index never aliases
  assign f_word0 = f_in_range ? mem[f_idx0[AW-1:0]] : 32'd0;
  assign f_word1 = f_in_range ? mem[f_idx1[AW-1:0]] : 32'd0;
  assign d_word  = d_in_range ? mem[d_idx[AW-1:0]]  : 32'd0;

  // A request carrying both rd and strobes is handled purely as a write
  assign d_is_write = |mem_d_wr_i;
  assign d_is_read  = mem_d_rd_i && !d_is_write;
  assign d_is_cmo   = mem_d_flush_i || mem_d_invalidate_i || mem_d_writeback_i;

  assign f_fire = mem_i_rd_i && accept;
  assign d_fire = (mem_d_rd_i || d_is_write || d_is_cmo) && accept;

  assign f_err_now  = !f_in_range;
  assign f_inst_now = f_in_range ? {f_word1, f_word0} : 64'd0;
  assign d_err_now  = (d_is_read || d_is_write) && !d_in_range;
  assign d_data_now = (d_is_read && d_in_range) ? d_word : 32'd0;

  // Byte-strobed write in the accept cycle; same-cycle fetch sees old data
  always_ff @(posedge clk_i) begin
    if (d_fire && d_is_write && d_in_range) begin
      for (int b = 0; b < 4; b++) begin
        if (mem_d_wr_i[b]) begin
          mem[d_idx[AW-1:0]][8*b +: 8] <= mem_d_data_wr_i[8*b +: 8];
        end
      end
    end
  end

  // Response pipelines; stage 0 captures the accept, last stage drives outputs
  logic        f_vld  [LATENCY];
  logic        f_err  [LATENCY];
  logic [63:0] f_inst [LATENCY];
  logic        d_vld  [LATENCY];
  logic        d_err  [LATENCY];
  logic [31:0] d_data [LATENCY];
  logic [10:0] d_tag  [LATENCY];

  // Shift responses one stage per cycle regardless of stall; reset drops them
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int s = 0; s < LATENCY; s++) begin
        f_vld[s]  <= 1'b0;
        f_err[s]  <= 1'b0;
        f_inst[s] <= 64'd0;
        d_vld[s]  <= 1'b0;
        d_err[s]  <= 1'b0;
        d_data[s] <= 32'd0;
        d_tag[s]  <= 11'd0;
      end
    end else begin
      f_vld[0]  <= f_fire;
      f_err[0]  <= f_fire && f_err_now;
      f_inst[0] <= f_fire ? f_inst_now : 64'd0;
      d_vld[0]  <= d_fire;
      d_err[0]  <= d_fire && d_err_now;
      d_data[0] <= d_fire ? d_data_now : 32'd0;
      d_tag[0]  <= d_fire ? mem_d_req_tag_i : 11'd0;
      for (int s = 1; s < LATENCY; s++) begin
        f_vld[s]  <= f_vld[s-1];
        f_err[s]  <= f_err[s-1];
        f_inst[s] <= f_inst[s-1];
        d_vld[s]  <= d_vld[s-1];
        d_err[s]  <= d_err[s-1];
        d_data[s] <= d_data[s-1];
        d_tag[s]  <= d_tag[s-1];
      end
    end
  end

  // Payload outputs are forced to zero whenever their strobe is low
  assign mem_i_valid_o    = f_vld[LATENCY-1];
  assign mem_i_error_o    = f_vld[LATENCY-1] && f_err[LATENCY-1];
  assign mem_i_inst_o     = f_vld[LATENCY-1] ? f_inst[LATENCY-1] : 64'd0;
  assign mem_d_ack_o      = d_vld[LATENCY-1];
  assign mem_d_error_o    = d_vld[LATENCY-1] && d_err[LATENCY-1];
  assign mem_d_data_rd_o  = d_vld[LATENCY-1] ? d_data[LATENCY-1] : 32'd0;
  assign mem_d_resp_tag_o = d_vld[LATENCY-1] ? d_tag[LATENCY-1] : 11'd0;

  // Inputs the responder deliberately ignores, plus always-zero offset bits
  logic unused_sigs;
  assign unused_sigs = ^{mem_i_flush_i, mem_i_invalidate_i, mem_d_cacheable_i,
                         mem_i_pc_i[2:0], f_off[1:0], d_off[1:0]};

endmodule
`default_nettype wire

// File: tb/tb_biriscv_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_biriscv_mem_responder
// Brief    : Directed bench for biriscv_mem_responder. Three instances with
//            LATENCY 1, 2 and 3 share the same stimulus. Each one is checked
//            every cycle against hand-computed responses at its own latency.
// Revision : 1.0 - initial release
// ============================================================================
module tb_biriscv_mem_responder;

  localparam logic [31:0] BASE  = 32'h8000_0000;
  localparam int          WORDS = 64;

  typedef struct {
    string       name;
    logic        stall;
    logic        f_rd;
    logic [31:0] pc;
    logic        f_err;
    logic [63:0] inst;
    logic        d_rd;
    logic [3:0]  d_wr;
    logic [2:0]  cmo;     // {flush, invalidate, writeback}
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [10:0] tag;
    logic        d_err;
    logic [31:0] rdata;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        i_rd = 1'b0;
  logic [31:0] pc = 32'd0;
  logic [31:0] d_addr = 32'd0;
  logic [31:0] d_wdata = 32'd0;
  logic        d_rd = 1'b0;
  logic [3:0]  d_wr = 4'd0;
  logic [10:0] d_tag = 11'd0;
  logic        d_flush = 1'b0;
  logic        d_inv = 1'b0;
  logic        d_wb = 1'b0;

  logic        i_acc   [1:3];
  logic        i_vld   [1:3];
  logic        i_err   [1:3];
  logic [63:0] i_inst  [1:3];
  logic        d_acc   [1:3];
  logic        d_ack   [1:3];
  logic        d_err   [1:3];
  logic [31:0] d_rdata [1:3];
  logic [10:0] d_rtag  [1:3];

  int checks = 0;
  int errors = 0;

  vec_t tbl[$];
  vec_t seq[$];

  always #5 clk = ~clk;

  for (genvar g = 1; g <= 3; g++) begin : g_dut
    biriscv_mem_responder #(
      .BASE_ADDR(BASE),
      .MEM_WORDS(WORDS),
      .LATENCY  (g)
    ) u_dut (
      .clk_i             (clk),
      .rst_i             (rst),
      .stall_i           (stall),
      .mem_i_rd_i        (i_rd),
      .mem_i_pc_i        (pc),
      .mem_i_flush_i     (1'b0),
      .mem_i_invalidate_i(1'b0),
      .mem_i_accept_o    (i_acc[g]),
      .mem_i_valid_o     (i_vld[g]),
      .mem_i_error_o     (i_err[g]),
      .mem_i_inst_o      (i_inst[g]),
      .mem_d_addr_i      (d_addr),
      .mem_d_data_wr_i   (d_wdata),
      .mem_d_rd_i        (d_rd),
      .mem_d_wr_i        (d_wr),
      .mem_d_req_tag_i   (d_tag),
      .mem_d_cacheable_i (1'b1),
      .mem_d_flush_i     (d_flush),
      .mem_d_invalidate_i(d_inv),
      .mem_d_writeback_i (d_wb),
      .mem_d_accept_o    (d_acc[g]),
      .mem_d_ack_o       (d_ack[g]),
      .mem_d_error_o     (d_err[g]),
      .mem_d_data_rd_o   (d_rdata[g]),
      .mem_d_resp_tag_o  (d_rtag[g])
    );
  end

  function automatic vec_t blank(string nm);
    vec_t v;
    v.name = nm;  v.stall = 1'b0;
    v.f_rd = 1'b0; v.pc = 32'd0; v.f_err = 1'b0; v.inst = 64'd0;
    v.d_rd = 1'b0; v.d_wr = 4'd0; v.cmo = 3'd0; v.addr = 32'd0;
    v.wdata = 32'd0; v.tag = 11'd0; v.d_err = 1'b0; v.rdata = 32'd0;
    return v;
  endfunction

  function automatic vec_t mk_rd(string nm, logic [31:0] a, logic [10:0] t,
                                 logic [31:0] d, logic e);
    vec_t v = blank(nm);
    v.d_rd = 1'b1; v.addr = a; v.tag = t; v.rdata = d; v.d_err = e;
    return v;
  endfunction

  function automatic vec_t mk_wr(string nm, logic [31:0] a, logic [3:0] s,
                                 logic [31:0] wd, logic [10:0] t, logic e);
    vec_t v = blank(nm);
    v.d_wr = s; v.addr = a; v.wdata = wd; v.tag = t; v.d_err = e;
    return v;
  endfunction

  function automatic vec_t mk_cmo(string nm, logic [31:0] a, logic [2:0] c,
                                  logic [10:0] t);
    vec_t v = blank(nm);
    v.cmo = c; v.addr = a; v.tag = t;
    return v;
  endfunction

  function automatic vec_t add_fetch(vec_t vin, logic [31:0] p,
                                     logic [63:0] ins, logic e);
    vec_t v = vin;
    v.f_rd = 1'b1; v.pc = p; v.inst = ins; v.f_err = e;
    return v;
  endfunction

  // Response an instance should show LATENCY cycles after this vector
  function automatic logic [110:0] exp_resp(vec_t v);
    logic fv, dv;
    fv = v.f_rd && !v.stall;
    dv = (v.d_rd || (v.d_wr != 4'd0) || (v.cmo != 3'd0)) && !v.stall;
    return {fv, fv & v.f_err, fv ? v.inst : 64'd0,
            dv, dv & v.d_err, dv ? v.rdata : 32'd0, dv ? v.tag : 11'd0};
  endfunction

  function automatic logic [110:0] got(int g);
    return {i_vld[g], i_err[g], i_inst[g],
            d_ack[g], d_err[g], d_rdata[g], d_rtag[g]};
  endfunction

  task automatic check(string what, logic [127:0] act, logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", what, act, exp);
    end
  endtask

  task automatic drive(vec_t v);
    stall   = v.stall;
    i_rd    = v.f_rd;
    pc      = v.pc;
    d_rd    = v.d_rd;
    d_wr    = v.d_wr;
    {d_flush, d_inv, d_wb} = v.cmo;
    d_addr  = v.addr;
    d_wdata = v.wdata;
    d_tag   = v.tag;
  endtask

  // Issue seq[] on consecutive cycles, then drain; every instance is
  // compared every cycle against the vector issued LATENCY cycles earlier.
  task automatic run_seq();
    int n;
    n = seq.size();
    for (int c = 0; c < n + 4; c++) begin
      vec_t cur;
      cur = (c < n) ? seq[c] : blank("idle");
      drive(cur);
      #1;
      for (int g = 1; g <= 3; g++) begin
        logic [110:0] e;
        string        nm;
        e  = '0;
        nm = "idle";
        if ((c - g) >= 0 && (c - g) < n) begin
          e  = exp_resp(seq[c-g]);
          nm = seq[c-g].name;
        end
        check($sformatf("%s accept L%0d c%0d", cur.name, g, c),
              {i_acc[g], d_acc[g]}, {2{!cur.stall}});
        check($sformatf("%s resp L%0d c%0d", nm, g, c), got(g), e);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_all_zero(string what);
    for (int g = 1; g <= 3; g++) begin
      check($sformatf("%s resp L%0d", what, g), got(g), 111'd0);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    vec_t v;

    // Single-transaction table, in memory-state order
    tbl.push_back(mk_wr("pre0", 32'h8000_0000, 4'hF, 32'h0000_0013, 11'h001, 1'b0));
    tbl.push_back(mk_wr("pre1", 32'h8000_0004, 4'hF, 32'h0010_0093, 11'h002, 1'b0));
    tbl.push_back(add_fetch(blank("fetch0"), 32'h8000_0000, 64'h0010_0093_0000_0013, 1'b0));
    tbl.push_back(mk_wr("clr4", 32'h8000_0010, 4'hF, 32'h0000_0000, 11'h003, 1'b0));
    tbl.push_back(mk_wr("strb", 32'h8000_0010, 4'b0101, 32'hAABB_CCDD, 11'h004, 1'b0));
    tbl.push_back(mk_rd("rd_strb", 32'h8000_0010, 11'h155, 32'h00BB_00DD, 1'b0));
    tbl.push_back(add_fetch(blank("fetch_lowbits"), 32'h8000_0005, 64'h0010_0093_0000_0013, 1'b0));
    tbl.push_back(mk_rd("rd_below", 32'h7FFF_FFFC, 11'h007, 32'h0, 1'b1));
    tbl.push_back(add_fetch(blank("fetch_above"), BASE + 32'(4 * WORDS), 64'd0, 1'b1));
    tbl.push_back(mk_wr("wr62", 32'h8000_00F8, 4'hF, 32'h1111_2222, 11'h009, 1'b0));
    tbl.push_back(mk_wr("wr63", 32'h8000_00FC, 4'hF, 32'h3333_4444, 11'h00A, 1'b0));
    tbl.push_back(add_fetch(blank("fetch_top"), 32'h8000_00FC, 64'h3333_4444_1111_2222, 1'b0));
    tbl.push_back(mk_wr("wr_above", BASE + 32'(4 * WORDS), 4'hF, 32'hDEAD_BEEF, 11'h00C, 1'b1));
    tbl.push_back(mk_rd("rd0_kept", 32'h8000_0000, 11'h00D, 32'h0000_0013, 1'b0));
    tbl.push_back(mk_rd("rd63", 32'h8000_00FC, 11'h7FF, 32'h3333_4444, 1'b0));
    tbl.push_back(mk_cmo("flush_oor", BASE + 32'(4 * WORDS), 3'b100, 11'h010));
    tbl.push_back(mk_cmo("wb_oor", 32'h7FFF_FFFC, 3'b001, 11'h011));
    tbl.push_back(mk_cmo("inval", 32'h8000_0000, 3'b010, 11'h012));
    v = mk_wr("rd_and_wr", 32'h8000_0008, 4'hF, 32'h1234_5678, 11'h020, 1'b0);
    v.d_rd = 1'b1;
    tbl.push_back(v);
    tbl.push_back(mk_rd("rd2", 32'h8000_0008, 11'h021, 32'h1234_5678, 1'b0));
    tbl.push_back(mk_wr("strb_hi", 32'h8000_0008, 4'b1000, 32'hFF00_0000, 11'h022, 1'b0));
    tbl.push_back(mk_rd("rd2_hi", 32'h8000_0008, 11'h023, 32'hFF34_5678, 1'b0));

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    for (int g = 1; g <= 3; g++) begin
      check($sformatf("reset accept L%0d", g), {i_acc[g], d_acc[g]}, 2'b00);
    end
    rst = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      seq.delete();
      seq.push_back(tbl[i]);
      run_seq();
    end

    // Back-to-back reads (tags 1,2,3) alongside back-to-back fetches
    seq.delete();
    seq.push_back(add_fetch(mk_rd("b2b_1", 32'h8000_0000, 11'h001, 32'h0000_0013, 1'b0),
                            32'h8000_0000, 64'h0010_0093_0000_0013, 1'b0));
    seq.push_back(add_fetch(mk_rd("b2b_2", 32'h8000_0004, 11'h002, 32'h0010_0093, 1'b0),
                            32'h8000_00F8, 64'h3333_4444_1111_2222, 1'b0));
    seq.push_back(mk_rd("b2b_3", 32'h8000_0010, 11'h003, 32'h00BB_00DD, 1'b0));
    run_seq();

    // Fetch and write to the same word: fetch sees old, next read sees new
    seq.delete();
    seq.push_back(add_fetch(mk_wr("raw_wr", 32'h8000_0000, 4'hF, 32'hCAFE_F00D, 11'h030, 1'b0),
                            32'h8000_0000, 64'h0010_0093_0000_0013, 1'b0));
    seq.push_back(add_fetch(mk_rd("raw_rd", 32'h8000_0000, 11'h031, 32'hCAFE_F00D, 1'b0),
                            32'h8000_0000, 64'h0010_0093_CAFE_F00D, 1'b0));
    run_seq();

    // Stall holds off new requests while an in-flight one still completes
    seq.delete();
    seq.push_back(mk_rd("pre_stall", 32'h8000_0010, 11'h044, 32'h00BB_00DD, 1'b0));
    for (int k = 0; k < 4; k++) begin
      v = add_fetch(mk_rd("stalled", 32'h8000_0010, 11'h045, 32'h00BB_00DD, 1'b0),
                    32'h8000_0000, 64'h0010_0093_CAFE_F00D, 1'b0);
      v.stall = 1'b1;
      seq.push_back(v);
    end
    seq.push_back(add_fetch(mk_rd("unstalled", 32'h8000_0010, 11'h045, 32'h00BB_00DD, 1'b0),
                            32'h8000_0000, 64'h0010_0093_CAFE_F00D, 1'b0));
    run_seq();

    // Reset one cycle after an accept discards the response (LATENCY >= 2)
    v = mk_rd("rst_drop", 32'h8000_0010, 11'h066, 32'h00BB_00DD, 1'b0);
    drive(v);
    #1;
    check_all_zero("rst_drop c0");
    @(posedge clk);
    #1;
    drive(blank("idle"));
    rst = 1'b1;
    #1;
    check("rst_drop c1 resp L1", got(1), exp_resp(v));
    check("rst_drop c1 resp L2", got(2), 111'd0);
    check("rst_drop c1 resp L3", got(3), 111'd0);
    for (int g = 1; g <= 3; g++) begin
      check($sformatf("rst_drop c1 accept L%0d", g), {i_acc[g], d_acc[g]}, 2'b00);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int c = 2; c < 6; c++) begin
      #1;
      check_all_zero($sformatf("rst_drop c%0d", c));
      @(posedge clk);
      #1;
    end

    // Memory survives reset
    seq.delete();
    seq.push_back(mk_rd("post_rst", 32'h8000_0010, 11'h067, 32'h00BB_00DD, 1'b0));
    run_seq();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
